ball_engine: RTL and testbench

- Parametrised successor to the single-speed ball mover. Owns ball position, direction, speed and the serve/score sequence for a two-paddle playfield of configurable size.
- Moves once per frame tick, not every clock.
- Wall and paddle collisions clamp position instead of overshooting.
- Each paddle hit speeds the ball up to a ceiling; a paddle miss produces a score pulse and a timed re-serve.
- Sits between the paddle controllers (paddle Y inputs) and the renderer/scoreboard (ball X/Y, score pulses).

---
 rtl/ball_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_ball_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Ball position, speed and serve/score sequencing for a two-paddle playfield.
// Optional BALL_SPIN_EN: a paddle hit retunes dy/dir_y from the hit offset.
module ball_engine #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int SPEED_INIT  = 3,
    parameter int SPEED_MAX   = 8,
    parameter int SERVE_TICKS = 60
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           tick_i,
    input  logic           pause_i,
    input  logic [5:0]     ball_width_i,
    input  logic [5:0]     wall_width_i,
    input  logic [5:0]     paddle_width_i,
    input  logic [Y_W-1:0] paddle_length_i,
    input  logic [Y_W-1:0] paddle_l_y_i,
    input  logic [Y_W-1:0] paddle_r_y_i,
    output logic [X_W-1:0] ball_x_o,
    output logic [Y_W-1:0] ball_y_o,
    output logic           ball_dir_x_o,
    output logic           serving_o,
    output logic           hit_o,
    output logic           score_l_o,
    output logic           score_r_o
);

    localparam int W     = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam int CNT_W = $clog2(SERVE_TICKS + 1);
    localparam int SPD_W = $clog2(SPEED_MAX + 2);

    typedef enum logic [1:0] {SERVE, MOVE, SCORED} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [SPD_W-1:0]   dx_q, dy_q;
    logic               dir_x_q, dir_y_q;
    logic               serving_q, hit_q, score_l_q, score_r_q;

    logic [W-1:0]       x_w, y_w, dx_w, dy_w, bw_w, ww_w, pw_w, plen_w, pl_w, pr_w;
    logic [W-1:0]       ctr_x, ctr_y, lim_r, edge_r, lim_b;
    logic               ov_l, ov_r;
    logic [SPD_W-1:0]   dx_inc;

    logic [W-1:0]       x_nxt_d, y_nxt_d;
    logic [SPD_W-1:0]   dx_d, dy_d;
    logic               dir_x_d, dir_y_d, hit_d, score_l_d, score_r_d;

    // All geometry is widened by one bit so sums and differences never wrap.
    assign x_w    = W'(x_q);
    assign y_w    = W'(y_q);
    assign dx_w   = W'(dx_q);
    assign dy_w   = W'(dy_q);
    assign bw_w   = W'(ball_width_i);
    assign ww_w   = W'(wall_width_i);
    assign pw_w   = W'(paddle_width_i);
    assign plen_w = W'(paddle_length_i);
    assign pl_w   = W'(paddle_l_y_i);
    assign pr_w   = W'(paddle_r_y_i);

    assign ctr_x  = (W'(SCREEN_W) - bw_w) >> 1;
    assign ctr_y  = (W'(SCREEN_H) - bw_w) >> 1;
    assign lim_r  = W'(SCREEN_W) - pw_w - bw_w;
    assign edge_r = W'(SCREEN_W) - bw_w;
    assign lim_b  = W'(SCREEN_H) - ww_w - bw_w;

    assign ov_l   = (y_w + bw_w > pl_w) && (y_w < pl_w + plen_w);
    assign ov_r   = (y_w + bw_w > pr_w) && (y_w < pr_w + plen_w);

    assign dx_inc = (dx_q >= SPD_W'(SPEED_MAX)) ? SPD_W'(SPEED_MAX) : dx_q + SPD_W'(1);

`ifdef BALL_SPIN_EN
    logic [W-1:0]        py_hit, q1_w, q3_w;
    logic signed [W:0]   off_s;
    logic [SPD_W-1:0]    dy_inc, dy_dec;

    assign py_hit = dir_x_q ? pl_w : pr_w;
    assign off_s  = $signed({1'b0, y_w + (bw_w >> 1)}) - $signed({1'b0, py_hit});
    assign q1_w   = plen_w >> 2;
    assign q3_w   = (plen_w * W'(3)) >> 2;
    assign dy_inc = (dy_q >= SPD_W'(SPEED_MAX)) ? SPD_W'(SPEED_MAX) : dy_q + SPD_W'(1);
    assign dy_dec = (dy_q > SPD_W'(1)) ? dy_q - SPD_W'(1) : SPD_W'(1);
`endif

    always_comb begin
        x_nxt_d   = x_w;
        y_nxt_d   = y_w;
        dx_d      = dx_q;
        dy_d      = dy_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        hit_d     = 1'b0;
        score_l_d = 1'b0;
        score_r_d = 1'b0;

        if (dir_x_q) begin
            if ((x_w < pw_w + dx_w) && ov_l) begin
                x_nxt_d = pw_w;
                dir_x_d = 1'b0;
                hit_d   = 1'b1;
            end else if (x_w < dx_w) begin
                x_nxt_d   = '0;
                score_r_d = 1'b1;
            end else begin
                x_nxt_d = x_w - dx_w;
            end
        end else begin
            if ((x_w + dx_w > lim_r) && ov_r) begin
                x_nxt_d = lim_r;
                dir_x_d = 1'b1;
                hit_d   = 1'b1;
            end else if (x_w + dx_w > edge_r) begin
                x_nxt_d   = edge_r;
                score_l_d = 1'b1;
            end else begin
                x_nxt_d = x_w + dx_w;
            end
        end

        if (hit_d) dx_d = dx_inc;

`ifdef BALL_SPIN_EN
        if (hit_d) begin
            if (off_s < $signed({1'b0, q1_w})) begin
                dy_d    = dy_inc;
                dir_y_d = 1'b1;
            end else if (off_s >= $signed({1'b0, q3_w})) begin
                dy_d    = dy_inc;
                dir_y_d = 1'b0;
            end else begin
                dy_d = dy_dec;
            end
        end
`endif

        // A wall bounce in the same tick overrides any spin-chosen dir_y.
        if (dir_y_q) begin
            if (y_w < ww_w + dy_w) begin
                y_nxt_d = ww_w;
                dir_y_d = 1'b0;
            end else begin
                y_nxt_d = y_w - dy_w;
            end
        end else begin
            if (y_w + dy_w > lim_b) begin
                y_nxt_d = lim_b;
                dir_y_d = 1'b1;
            end else begin
                y_nxt_d = y_w + dy_w;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= SERVE;
            cnt_q     <= '0;
            x_q       <= ctr_x[X_W-1:0];
            y_q       <= ctr_y[Y_W-1:0];
            dx_q      <= SPD_W'(SPEED_INIT);
            dy_q      <= SPD_W'(SPEED_INIT);
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            serving_q <= 1'b1;
            hit_q     <= 1'b0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
        end else begin
            hit_q     <= 1'b0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
            if (tick_i && !pause_i) begin
                case (state_q)
                    SERVE: begin
                        x_q <= ctr_x[X_W-1:0];
                        y_q <= ctr_y[Y_W-1:0];
                        if (cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
                            cnt_q     <= '0;
                            state_q   <= MOVE;
                            serving_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    MOVE: begin
                        x_q       <= x_nxt_d[X_W-1:0];
                        dir_x_q   <= dir_x_d;
                        dx_q      <= dx_d;
                        hit_q     <= hit_d;
                        score_l_q <= score_l_d;
                        score_r_q <= score_r_d;
                        if (score_l_d || score_r_d) begin
                            state_q <= SCORED;
                        end else begin
                            y_q     <= y_nxt_d[Y_W-1:0];
                            dir_y_q <= dir_y_d;
                            dy_q    <= dy_d;
                        end
                    end
                    SCORED: begin
                        // A miss only happens while travelling toward the
                        // missing side, so dir_x already serves toward it.
                        x_q       <= ctr_x[X_W-1:0];
                        y_q       <= ctr_y[Y_W-1:0];
                        dx_q      <= SPD_W'(SPEED_INIT);
                        dy_q      <= SPD_W'(SPEED_INIT);
                        state_q   <= SERVE;
                        serving_q <= 1'b1;
                    end
                    default: begin
                        state_q   <= SERVE;
                        serving_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign ball_x_o     = x_q;
    assign ball_y_o     = y_q;
    assign ball_dir_x_o = dir_x_q;
    assign serving_o    = serving_q;
    assign hit_o        = hit_q;
    assign score_l_o    = score_l_q;
    assign score_r_o    = score_r_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: serve timing, walls, paddle hits, speed ceiling,
// misses, pause and reset. Honours BALL_SPIN_EN for the post-hit dy check.
module tb_ball_engine;

    logic       clk_i = 1'b0;
    logic       reset_i, tick_i, pause_i;
    logic [5:0] ball_width_i, wall_width_i, paddle_width_i;
    logic [8:0] paddle_length_i, paddle_l_y_i, paddle_r_y_i;
    logic [9:0] ball_x_o;
    logic [8:0] ball_y_o;
    logic       ball_dir_x_o, serving_o, hit_o, score_l_o, score_r_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    ball_engine dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .tick_i         (tick_i),
        .pause_i        (pause_i),
        .ball_width_i   (ball_width_i),
        .wall_width_i   (wall_width_i),
        .paddle_width_i (paddle_width_i),
        .paddle_length_i(paddle_length_i),
        .paddle_l_y_i   (paddle_l_y_i),
        .paddle_r_y_i   (paddle_r_y_i),
        .ball_x_o       (ball_x_o),
        .ball_y_o       (ball_y_o),
        .ball_dir_x_o   (ball_dir_x_o),
        .serving_o      (serving_o),
        .hit_o          (hit_o),
        .score_l_o      (score_l_o),
        .score_r_o      (score_r_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One active tick, sampled on the following falling edge.
    task automatic do_tick();
        @(negedge clk_i);
        tick_i = 1'b1;
        @(negedge clk_i);
        tick_i = 1'b0;
    endtask

    // sel: 0 = hit, 1 = score_l, 2 = score_r
    task automatic tick_until(input int sel, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            do_tick();
            if ((sel == 0 && hit_o) || (sel == 1 && score_l_o) || (sel == 2 && score_r_o))
                seen = 1'b1;
        end
    endtask

    task automatic serve_and_check(input string tag);
        for (int i = 1; i < 60; i++) begin
            do_tick();
            check({tag, "_serving"}, serving_o, 1);
            check({tag, "_x_hold"}, ball_x_o, 315);
            check({tag, "_y_hold"}, ball_y_o, 235);
        end
        do_tick();
        check({tag, "_launch"}, serving_o, 0);
        check({tag, "_x_launch"}, ball_x_o, 315);
    endtask

    task automatic pulse_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        tick_i  = 1'b1;
        @(negedge clk_i);
        check("rst_x", ball_x_o, 315);
        check("rst_y", ball_y_o, 235);
        check("rst_serving", serving_o, 1);
        check("rst_dir_x", ball_dir_x_o, 1);
        reset_i = 1'b1;
        tick_i  = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    int clamp_t[5] = '{614, 16, 614, 16, 614};
    int dir_t[5]   = '{1, 0, 1, 0, 1};
    int step_t[5]  = '{609, 22, 607, 24, 606};

    initial begin
        bit seen;
        reset_i = 1'b0; tick_i = 1'b0; pause_i = 1'b0;
        ball_width_i = 6'd10; wall_width_i = 6'd8; paddle_width_i = 6'd16;
        paddle_length_i = 9'd480; paddle_l_y_i = 9'd0; paddle_r_y_i = 9'd0;

        repeat (2) @(negedge clk_i);
        check("reset_x", ball_x_o, 315);
        check("reset_y", ball_y_o, 235);
        check("reset_serving", serving_o, 1);
        check("reset_dir_x", ball_dir_x_o, 1);
        check("reset_hit", hit_o, 0);
        check("reset_score_l", score_l_o, 0);
        check("reset_score_r", score_r_o, 0);
        reset_i = 1'b1;

        repeat (5) @(negedge clk_i);
        check("idle_clk_no_move", ball_x_o, 315);

        serve_and_check("serve1");
        do_tick();
        check("first_move_x", ball_x_o, 312);
        check("first_move_y", ball_y_o, 232);

        repeat (74) do_tick();
        check("n75_x", ball_x_o, 90);
        check("n75_y", ball_y_o, 10);
        do_tick();
        check("top_wall_x", ball_x_o, 87);
        check("top_wall_y", ball_y_o, 8);
        repeat (23) do_tick();
        check("n99_x", ball_x_o, 18);
        check("n99_y", ball_y_o, 77);
        check("n99_hit", hit_o, 0);
        do_tick();
        check("hit1_x", ball_x_o, 16);
        check("hit1_y", ball_y_o, 80);
        check("hit1_dir_x", ball_dir_x_o, 0);
        check("hit1_pulse", hit_o, 1);
        check("hit1_no_score", score_r_o, 0);
        @(negedge clk_i);
        check("hit1_pulse_end", hit_o, 0);
        do_tick();
        check("dx4_x", ball_x_o, 20);
`ifdef BALL_SPIN_EN
        check("spin_dy4_up", ball_y_o, 76);
`else
        check("nospin_dy3", ball_y_o, 83);
`endif
        repeat (126) do_tick();
        check("m127_x", ball_x_o, 524);
`ifndef BALL_SPIN_EN
        check("m127_y", ball_y_o, 461);
`endif
        do_tick();
        check("m128_x", ball_x_o, 528);
`ifndef BALL_SPIN_EN
        check("bottom_wall_y", ball_y_o, 462);
`endif
        do_tick();
`ifndef BALL_SPIN_EN
        check("bottom_bounce_y", ball_y_o, 459);
`endif

        for (int k = 0; k < 5; k++) begin
            tick_until(0, 300, seen);
            check("hit_seen", seen, 1);
            check("hit_clamp_x", ball_x_o, clamp_t[k]);
            check("hit_dir_x", ball_dir_x_o, dir_t[k]);
            do_tick();
            check("speedup_step_x", ball_x_o, step_t[k]);
        end

        paddle_l_y_i = 9'd479;
        tick_until(2, 200, seen);
        check("score_r_seen", seen, 1);
        check("miss_l_x", ball_x_o, 0);
        check("miss_l_score_l", score_l_o, 0);
        check("miss_l_dir_x", ball_dir_x_o, 1);
        check("miss_l_serving", serving_o, 0);
        @(negedge clk_i);
        check("score_r_pulse_end", score_r_o, 0);
        paddle_l_y_i = 9'd0;
        paddle_r_y_i = 9'd479;
        do_tick();
        check("scored_r_x", ball_x_o, 315);
        check("scored_r_y", ball_y_o, 235);
        check("scored_r_dir_x", ball_dir_x_o, 1);
        check("scored_r_serving", serving_o, 1);
        serve_and_check("serve2");
        do_tick();
        check("serve2_dx3", ball_x_o, 312);
        check("serve2_dy3", (ball_y_o == 9'd232) || (ball_y_o == 9'd238), 1);

        tick_until(1, 400, seen);
        check("score_l_seen", seen, 1);
        check("miss_r_x", ball_x_o, 630);
        check("miss_r_dir_x", ball_dir_x_o, 0);
        check("miss_r_score_r", score_r_o, 0);
        @(negedge clk_i);
        check("score_l_pulse_end", score_l_o, 0);
        do_tick();
        check("scored_l_x", ball_x_o, 315);
        check("scored_l_y", ball_y_o, 235);
        check("scored_l_dir_x", ball_dir_x_o, 0);
        check("scored_l_serving", serving_o, 1);
        serve_and_check("serve3");
        do_tick();
        check("serve3_dx_reset", ball_x_o, 318);

        pause_i = 1'b1;
        repeat (10) do_tick();
        check("pause_x", ball_x_o, 318);
        check("pause_serving", serving_o, 0);
        pause_i = 1'b0;
        do_tick();
        check("unpause_x", ball_x_o, 321);

        pulse_reset();
        repeat (30) do_tick();
        check("mid_serve_serving", serving_o, 1);
        pulse_reset();
        serve_and_check("serve4");
        do_tick();
        check("serve4_x", ball_x_o, 312);
        check("serve4_y", ball_y_o, 232);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
